eth_frame_log_arbiter: RTL

- Merges the per-interface log streams of N frame loops into one AXI4-Stream log output, for multi-port detector builds with more than the fixed A/B pair.
- Arbitrates per frame: once granted, a channel keeps the output until its tlast. Output beats carry the source channel index.
- Round-robin or fixed-priority mode, optional runaway-frame truncation, and per-channel frame and truncation counters for the register block.

---
 rtl/eth_frame_log_arbiter_pkg.sv | 19 +
 rtl/eth_frame_log_arbiter_if.sv | 33 +++
 rtl/eth_frame_log_arb_select.sv | 53 +++++
 rtl/eth_frame_log_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/eth_frame_log_arbiter_pkg.sv
// Shared types and constants for the frame-granular log stream arbiter.
// Imported by the grant selector and the top level.
package eth_frame_log_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;
  localparam int CNT_W     = 32;

  function automatic logic [CNT_W-1:0] sat_inc32(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/eth_frame_log_arbiter_if.sv
// Bundle of N input log streams plus the merged output stream.
// The slave view belongs to the arbiter; the master view belongs to whoever feeds and drains it.
interface eth_frame_log_arbiter_if #(
  parameter int C_NUM_CHANNELS   = 2,
  parameter int C_AXIS_LOG_WIDTH = 64,
  parameter int C_ID_WIDTH       = $clog2(C_NUM_CHANNELS)
);
  logic [C_NUM_CHANNELS*C_AXIS_LOG_WIDTH-1:0] s_axis_log_tdata;
  logic [C_NUM_CHANNELS-1:0]                  s_axis_log_tlast;
  logic [C_NUM_CHANNELS-1:0]                  s_axis_log_tvalid;
  logic [C_NUM_CHANNELS-1:0]                  s_axis_log_tready;

  logic [C_AXIS_LOG_WIDTH-1:0]                m_axis_log_tdata;
  logic [C_ID_WIDTH-1:0]                      m_axis_log_tid;
  logic                                       m_axis_log_tlast;
  logic                                       m_axis_log_tvalid;
  logic                                       m_axis_log_tready;

  modport master (
    output s_axis_log_tdata, s_axis_log_tlast, s_axis_log_tvalid,
    input  s_axis_log_tready,
    input  m_axis_log_tdata, m_axis_log_tid, m_axis_log_tlast, m_axis_log_tvalid,
    output m_axis_log_tready
  );

  modport slave (
    input  s_axis_log_tdata, s_axis_log_tlast, s_axis_log_tvalid,
    output s_axis_log_tready,
    output m_axis_log_tdata, m_axis_log_tid, m_axis_log_tlast, m_axis_log_tvalid,
    input  m_axis_log_tready
  );

endinterface

// File: rtl/eth_frame_log_arb_select.sv
// Combinational grant choice: lowest valid index, or first valid index after the
// round-robin pointer (modulo channel count).
module eth_frame_log_arb_select
  import eth_frame_log_arbiter_pkg::*;
#(
  parameter int C_NUM_CHANNELS = 2,
  parameter int C_ARB_MODE     = ARB_RR,
  parameter int C_ID_WIDTH     = $clog2(C_NUM_CHANNELS)
) (
  input  logic [C_NUM_CHANNELS-1:0] i_tvalid,
  input  logic [C_ID_WIDTH-1:0]     i_rr_ptr,
  output logic [C_ID_WIDTH-1:0]     o_grant,
  output logic                      o_found
);

  logic [C_ID_WIDTH-1:0] w_fix_grant;
  logic                  w_fix_found;
  logic [C_ID_WIDTH-1:0] w_rr_grant;
  logic                  w_rr_found;
  int                    w_best_dist;
  int                    w_dist;

  always_comb begin
    w_fix_grant = '0;
    w_fix_found = 1'b0;
    for (int i = C_NUM_CHANNELS - 1; i >= 0; i--) begin
      if (i_tvalid[i]) begin
        w_fix_grant = C_ID_WIDTH'(i);
        w_fix_found = 1'b1;
      end
    end
  end

  // Distance 0 is the channel just after the pointer; the pointer itself is farthest.
  always_comb begin
    w_rr_grant  = '0;
    w_rr_found  = 1'b0;
    w_best_dist = C_NUM_CHANNELS;
    w_dist      = 0;
    for (int i = 0; i < C_NUM_CHANNELS; i++) begin
      w_dist = (i + C_NUM_CHANNELS - 1 - int'(i_rr_ptr)) % C_NUM_CHANNELS;
      if (i_tvalid[i] && (w_dist < w_best_dist)) begin
        w_best_dist = w_dist;
        w_rr_grant  = C_ID_WIDTH'(i);
        w_rr_found  = 1'b1;
      end
    end
  end

  assign o_grant = (C_ARB_MODE == ARB_FIXED) ? w_fix_grant : w_rr_grant;
  assign o_found = (C_ARB_MODE == ARB_FIXED) ? w_fix_found : w_rr_found;

endmodule

// File: rtl/eth_frame_log_arbiter.sv
// Frame-granular merge of N log streams into one tagged stream, with optional
// runaway-frame truncation and per-channel frame/truncation counters.
module eth_frame_log_arbiter
  import eth_frame_log_arbiter_pkg::*;
#(
  parameter int C_NUM_CHANNELS   = 2,
  parameter int C_AXIS_LOG_WIDTH = 64,
  parameter int C_ARB_MODE       = ARB_RR,
  parameter int C_MAX_BEATS      = 0,
  parameter int C_ID_WIDTH       = $clog2(C_NUM_CHANNELS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         srst,
  input  logic                         enable,
  eth_frame_log_arbiter_if.slave       bus,
  output logic [C_NUM_CHANNELS*32-1:0] frame_count,
  output logic [C_NUM_CHANNELS*32-1:0] trunc_count
);

  localparam int BCW = (C_MAX_BEATS > 0) ? $clog2(C_MAX_BEATS + 1) : 1;
  localparam logic [BCW:0] MAXB = (BCW + 1)'(C_MAX_BEATS);
  localparam logic [C_ID_WIDTH-1:0] RR_INIT = C_ID_WIDTH'(C_NUM_CHANNELS - 1);

  state_t                       r_state;
  logic [C_ID_WIDTH-1:0]        r_grant;
  logic [C_ID_WIDTH-1:0]        r_rr_ptr;
  logic [BCW-1:0]               r_beat_cnt;
  logic [C_AXIS_LOG_WIDTH-1:0]  r_m_tdata;
  logic [C_ID_WIDTH-1:0]        r_m_tid;
  logic                         r_m_tlast;
  logic                         r_m_tvalid;
  logic [CNT_W-1:0]             r_frame_cnt [C_NUM_CHANNELS];
  logic [CNT_W-1:0]             r_trunc_cnt [C_NUM_CHANNELS];

  logic [C_ID_WIDTH-1:0]        w_sel;
  logic                         w_sel_found;
  logic                         w_g_tvalid;
  logic                         w_g_tlast;
  logic [C_AXIS_LOG_WIDTH-1:0]  w_g_tdata;
  logic                         w_busy;
  logic                         w_drain;
  logic                         w_ready_g;
  logic                         w_acc;
  logic [BCW:0]                 w_cnt_nxt;
  logic                         w_trunc;
  logic                         w_frame_done;
  logic [C_NUM_CHANNELS-1:0]    w_tready;

  eth_frame_log_arb_select #(
    .C_NUM_CHANNELS (C_NUM_CHANNELS),
    .C_ARB_MODE     (C_ARB_MODE),
    .C_ID_WIDTH     (C_ID_WIDTH)
  ) u_select (
    .i_tvalid (bus.s_axis_log_tvalid),
    .i_rr_ptr (r_rr_ptr),
    .o_grant  (w_sel),
    .o_found  (w_sel_found)
  );

  always_comb begin
    w_g_tvalid = 1'b0;
    w_g_tlast  = 1'b0;
    w_g_tdata  = '0;
    for (int i = 0; i < C_NUM_CHANNELS; i++) begin
      if (r_grant == C_ID_WIDTH'(i)) begin
        w_g_tvalid = bus.s_axis_log_tvalid[i];
        w_g_tlast  = bus.s_axis_log_tlast[i];
        w_g_tdata  = bus.s_axis_log_tdata[i*C_AXIS_LOG_WIDTH +: C_AXIS_LOG_WIDTH];
      end
    end
  end

  assign w_busy    = (r_state == ST_BUSY);
  assign w_drain   = (r_state == ST_DRAIN);
  // DRAIN ignores output back-pressure since its beats never reach the output.
  assign w_ready_g = (w_busy || w_drain) && (!r_m_tvalid || bus.m_axis_log_tready || w_drain);
  assign w_acc     = w_ready_g && w_g_tvalid;
  assign w_cnt_nxt = {1'b0, r_beat_cnt} + {{BCW{1'b0}}, 1'b1};
  assign w_trunc   = (C_MAX_BEATS > 0) && w_busy && w_acc && !w_g_tlast && (w_cnt_nxt == MAXB);
  assign w_frame_done = w_busy && w_acc && (w_g_tlast || w_trunc);

  always_comb begin
    w_tready = '0;
    for (int i = 0; i < C_NUM_CHANNELS; i++) begin
      if (r_grant == C_ID_WIDTH'(i)) w_tready[i] = w_ready_g;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_rr_ptr   <= RR_INIT;
      r_beat_cnt <= '0;
      r_m_tdata  <= '0;
      r_m_tid    <= '0;
      r_m_tlast  <= 1'b0;
      r_m_tvalid <= 1'b0;
    end else if (srst) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_rr_ptr   <= RR_INIT;
      r_beat_cnt <= '0;
      r_m_tdata  <= '0;
      r_m_tid    <= '0;
      r_m_tlast  <= 1'b0;
      r_m_tvalid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable && w_sel_found) begin
            r_grant    <= w_sel;
            r_beat_cnt <= '0;
            r_state    <= ST_BUSY;
            if (C_ARB_MODE == ARB_RR) r_rr_ptr <= w_sel;
          end
        end
        ST_BUSY: begin
          if (w_acc) begin
            r_beat_cnt <= w_cnt_nxt[BCW-1:0];
            if (w_g_tlast)    r_state <= ST_IDLE;
            else if (w_trunc) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_acc && w_g_tlast) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_busy && w_acc) begin
        r_m_tdata  <= w_g_tdata;
        r_m_tid    <= r_grant;
        r_m_tlast  <= w_g_tlast || w_trunc;
        r_m_tvalid <= 1'b1;
      end else if (bus.m_axis_log_tready) begin
        r_m_tvalid <= 1'b0;
      end
    end
  end

  // Only the granted channel can finish or truncate a frame, so one index suffices.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < C_NUM_CHANNELS; i++) begin
        r_frame_cnt[i] <= '0;
        r_trunc_cnt[i] <= '0;
      end
    end else if (srst) begin
      for (int i = 0; i < C_NUM_CHANNELS; i++) begin
        r_frame_cnt[i] <= '0;
        r_trunc_cnt[i] <= '0;
      end
    end else begin
      if (w_frame_done) r_frame_cnt[r_grant] <= r_frame_cnt[r_grant] + 32'd1;
      if (w_trunc)      r_trunc_cnt[r_grant] <= sat_inc32(r_trunc_cnt[r_grant]);
    end
  end

  assign bus.s_axis_log_tready = w_tready;
  assign bus.m_axis_log_tdata  = r_m_tdata;
  assign bus.m_axis_log_tid    = r_m_tid;
  assign bus.m_axis_log_tlast  = r_m_tlast;
  assign bus.m_axis_log_tvalid = r_m_tvalid;

  for (genvar gi = 0; gi < C_NUM_CHANNELS; gi++) begin : g_cnt_out
    assign frame_count[gi*32 +: 32] = r_frame_cnt[gi];
    assign trunc_count[gi*32 +: 32] = r_trunc_cnt[gi];
  end

endmodule
